// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arb_pkg;

  // Arbiter FSM: nothing granted, or one requester holding the resource.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Index of the set bit in a one-hot vector (all-zero vector maps to 0).
  function automatic logic [31:0] onehot2idx(input logic [31:0] oh);
    logic [31:0] idx;
    idx = 32'd0;
    for (int i = 0; i < 32; i++) begin
      idx = idx | (oh[i] ? 32'(i) : 32'd0);
    end
    return idx;
  endfunction

  // Effective burst length: a zero weight still earns one beat.
  function automatic logic [31:0] weff(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/sp_arbiter.sv
// Combinational static-priority picker: one-hot grant to the highest-priority
// active request. LSB_HIGH=1 gives bit 0 the highest priority.
module sp_arbiter #(
  parameter int N        = 4,
  parameter bit LSB_HIGH = 1'b1
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic found_s;
  int   idx_s;

  // Walk requests in priority order and keep the first one found.
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < N; i++) begin
      idx_s = LSB_HIGH ? i : (N - 1 - i);
      if (req[idx_s] && !found_s) begin
        gnt[idx_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Registered weighted round-robin arbiter. A winner keeps the grant for up
// to its weight in beats; on release the priority pointer moves past it and
// a new winner is picked in the same edge.
module wrr_arbiter
  import wrr_arb_pkg::*;
#(
  parameter  int NUM = 4,
  parameter  int WW  = 4,
  localparam int IDW = $clog2(NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM-1:0]      req,
  input  logic [NUM*WW-1:0]   weight,
  output logic [NUM-1:0]      gnt,
  output logic                gnt_vld,
  output logic [IDW-1:0]      gnt_id
);

  state_e           state_r;
  logic [IDW-1:0]   ptr_r;
  logic [WW-1:0]    cnt_r;
  logic [WW-1:0]    weff_r;
  logic [NUM-1:0]   gnt_r;
  logic             gnt_vld_r;
  logic [IDW-1:0]   gnt_id_r;

  logic             release_s;
  logic [IDW-1:0]   nxt_ptr_s;
  logic [IDW-1:0]   arb_ptr_s;
  logic [NUM-1:0]   mask_s;
  logic [NUM-1:0]   pick_m_s;
  logic [NUM-1:0]   pick_u_s;
  logic [NUM-1:0]   pick_s;
  logic [IDW-1:0]   pick_id_s;
  logic [WW-1:0]    pick_weff_s;

  // Burst ends when the owner drops its request or spends its last credit.
  always_comb begin
    if (state_r == GRANT) begin
      release_s = !req[gnt_id_r] || (cnt_r == weff_r);
    end else begin
      release_s = 1'b0;
    end
  end

  // Pointer just past the current owner; used as priority base on release.
  always_comb begin
    if (gnt_id_r == IDW'(NUM - 1)) begin
      nxt_ptr_s = '0;
    end else begin
      nxt_ptr_s = gnt_id_r + IDW'(1);
    end
    if (release_s) begin
      arb_ptr_s = nxt_ptr_s;
    end else begin
      arb_ptr_s = ptr_r;
    end
  end

  // Requests at or above the priority pointer form the masked set.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < NUM; i++) begin
      mask_s[i] = (i >= int'(arb_ptr_s));
    end
  end

  sp_arbiter #(.N(NUM), .LSB_HIGH(1'b1)) u_pick_masked (
    .req (req & mask_s),
    .gnt (pick_m_s)
  );

  sp_arbiter #(.N(NUM), .LSB_HIGH(1'b1)) u_pick_unmasked (
    .req (req),
    .gnt (pick_u_s)
  );

  // Prefer the masked winner; fall back to the unmasked one to wrap around.
  always_comb begin
    if (|pick_m_s) begin
      pick_s = pick_m_s;
    end else begin
      pick_s = pick_u_s;
    end
    pick_id_s   = IDW'(onehot2idx(32'(pick_s)));
    pick_weff_s = WW'(weff(32'(weight[int'(pick_id_s)*WW +: WW])));
  end

  // FSM, pointer, credit counter and registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      cnt_r     <= '0;
      weff_r    <= '0;
      gnt_r     <= '0;
      gnt_vld_r <= 1'b0;
      gnt_id_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req) begin
            state_r   <= GRANT;
            gnt_r     <= pick_s;
            gnt_vld_r <= 1'b1;
            gnt_id_r  <= pick_id_s;
            weff_r    <= pick_weff_s;
            cnt_r     <= WW'(1);
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (release_s) begin
            ptr_r <= nxt_ptr_s;
            if (|req) begin
              state_r   <= GRANT;
              gnt_r     <= pick_s;
              gnt_vld_r <= 1'b1;
              gnt_id_r  <= pick_id_s;
              weff_r    <= pick_weff_s;
              cnt_r     <= WW'(1);
            end else begin
              state_r   <= IDLE;
              gnt_r     <= '0;
              gnt_vld_r <= 1'b0;
              gnt_id_r  <= '0;
              cnt_r     <= '0;
            end
          end else begin
            cnt_r <= cnt_r + WW'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          gnt_r     <= '0;
          gnt_vld_r <= 1'b0;
          gnt_id_r  <= '0;
          cnt_r     <= '0;
        end
      endcase
    end
  end

  assign gnt     = gnt_r;
  assign gnt_vld = gnt_vld_r;
  assign gnt_id  = gnt_id_r;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Scoreboard bench for wrr_arbiter: the driver applies inputs on the falling
// edge and pushes the reference model's expected outputs; the monitor pops
// and compares just after each rising edge.
module tb_wrr_arbiter;

  localparam int NUM = 4;
  localparam int WW  = 4;
  localparam int IDW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM-1:0]      req;
  logic [NUM*WW-1:0]   weight;
  logic [NUM-1:0]      gnt;
  logic                gnt_vld;
  logic [IDW-1:0]      gnt_id;

  typedef struct packed {
    logic [NUM-1:0] g;
    logic           v;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model state: who owns the resource, beats used, burst quota,
  // and the requester that has first claim at the next arbitration.
  int m_owner = -1;
  int m_used  = 0;
  int m_quota = 0;
  int m_ptr   = 0;

  always #5 clk = ~clk;

  wrr_arbiter #(.NUM(NUM), .WW(WW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .weight  (weight),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // Round-robin search starting at p, wrapping around.
  function automatic int rr_pick(input logic [NUM-1:0] r, input int p);
    for (int k = 0; k < NUM; k++) begin
      if (r[(p + k) % NUM]) return (p + k) % NUM;
    end
    return -1;
  endfunction

  function automatic int wt(input logic [NUM*WW-1:0] w, input int i);
    int v;
    v = int'(w[i*WW +: WW]);
    return (v == 0) ? 1 : v;
  endfunction

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_step();
    int p;
    if (rst) begin
      m_owner = -1; m_used = 0; m_quota = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      p = rr_pick(req, m_ptr);
      if (p >= 0) begin
        m_owner = p; m_used = 0; m_quota = wt(weight, p);
      end
    end else begin
      if (req[m_owner]) m_used++;
      if (!req[m_owner] || m_used >= m_quota) begin
        m_ptr   = (m_owner + 1) % NUM;
        m_owner = -1;
        p = rr_pick(req, m_ptr);
        if (p >= 0) begin
          m_owner = p; m_used = 0; m_quota = wt(weight, p);
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic [NUM-1:0] rq,
                       input logic [NUM*WW-1:0] w, input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      rst = r; req = rq; weight = w;
      model_step();
      e.g  = (m_owner >= 0) ? NUM'(1 << m_owner) : '0;
      e.v  = (m_owner >= 0);
      e.id = (m_owner >= 0) ? IDW'(m_owner) : '0;
      exp_q.push_back(e);
      @(negedge clk);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (gnt !== e.g || gnt_vld !== e.v || gnt_id !== e.id) begin
          fails++;
          $display("FAIL grant cycle %0d: got gnt=%b vld=%b id=%0d, want gnt=%b vld=%b id=%0d",
                   cyc, gnt, gnt_vld, gnt_id, e.g, e.v, e.id);
        end
        if (gnt_vld && ((gnt & (gnt - 1'b1)) != '0)) begin
          fails++;
          $display("FAIL onehot cycle %0d: got gnt=%b, want one-hot", cyc, gnt);
        end
      end
    end
  end

  initial begin
    logic [NUM-1:0]    rq;
    logic [NUM*WW-1:0] w;
    rst = 1'b1; req = '0; weight = '0;

    // 1: reset held with all requesting, then first grant to requester 0.
    drive(1'b1, 4'b1111, 16'h1111, 3);
    // 2: unit weights, one beat each in rotation.
    drive(1'b0, 4'b1111, 16'h1111, 9);
    // 3: mixed weights including a zero weight.
    drive(1'b1, 4'b0000, 16'h0213, 1);
    drive(1'b0, 4'b1111, 16'h0213, 16);
    // 4: early release of requester 0, then requester 2 burst, then idle.
    drive(1'b1, 4'b0000, 16'h0404, 1);
    drive(1'b0, 4'b0101, 16'h0404, 3);
    drive(1'b0, 4'b0100, 16'h0404, 5);
    drive(1'b0, 4'b0000, 16'h0404, 3);
    // 5: sole requester, weight changed mid-burst.
    drive(1'b1, 4'b0000, 16'h2000, 1);
    drive(1'b0, 4'b1000, 16'h2000, 2);
    drive(1'b0, 4'b1000, 16'h7000, 12);
    // 6: reset during a burst, then full regrant.
    drive(1'b1, 4'b0000, 16'h0050, 1);
    drive(1'b0, 4'b0010, 16'h0050, 3);
    drive(1'b1, 4'b0010, 16'h0050, 1);
    drive(1'b0, 4'b0010, 16'h0050, 8);

    // Randomised traffic with occasional weight changes and resets.
    rq = 4'b0000;
    w  = 16'h1234;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) w = NUM*WW'($urandom());
      for (int b = 0; b < NUM; b++) begin
        if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
      end
      drive(($urandom_range(0, 199) == 0), rq, w, 1);
    end
    drive(1'b0, 4'b0000, w, 2);

    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
Registered weighted round-robin arbiter that shares one resource between NUM requesters. A winner holds the grant for a burst of up to its programmed weight in consecutive beats, then the priority pointer rotates past it. Selection uses two static-priority pickers, one masked and one unmasked. The block sits in front of the shared resource and replaces pure static priority where starvation is not acceptable.

Parameters:
NUM, 4, number of requesters (>=2)
WW, 4, width of each per-requester weight field
IDW, $clog2(NUM), width of gnt_id (derived, not overridable)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  NUM  request per requester, level, may drop at any time
weight  input  NUM*WW  weight of requester i in bits [i*WW +: WW], quasi-static config
gnt  output  NUM  registered one-hot grant, all-zero when idle
gnt_vld  output  1  registered, equals |gnt
gnt_id  output  IDW  registered index of the granted requester, 0 when idle

Behaviour:
- One clock, clk. Synchronous active-high reset, rst.
- Reset values: gnt=0, gnt_vld=0, gnt_id=0, ptr=0 (index 0 highest priority), cnt=0, state IDLE.
- rst asserted mid-burst: outputs are zero after the next edge; no partial credit is retained.
- Beat: a cycle with gnt[i]=1 and req[i]=1.
- States: IDLE (no grant) and GRANT (one grant is held).
- IDLE: at the edge with |req=1, pick a winner and go to GRANT. gnt is visible one cycle after req is first sampled high (latency 1).
- IDLE with req=0: stay in IDLE.
- On grant start, latch weff = (weight[i]==0) ? 1 : weight[i] and set cnt=1. Weight changes during a burst are ignored.
- GRANT, beat with cnt<weff: hold the grant and increment cnt.
- GRANT, release: release at the edge where req[i]=0 (that cycle is not a beat) or where a beat occurs with cnt==weff.
- On release, set ptr=(i+1) mod NUM and re-arbitrate in the same edge. There is no idle bubble between bursts.
- If nothing is requesting at release, go to IDLE.
- Pick rule: masked = req AND (bits >= ptr). Take the lowest set bit of masked if nonzero, else the lowest set bit of req (wrap-around).
- The releasing requester is re-granted only if it is the sole requester after credit exhaustion. Its credit is reloaded from the current weight.
- Requests that drop while not granted have no effect. No request is lost as long as it stays asserted.
- gnt stays one-hot or zero at all times. gnt_id and gnt_vld are registered alongside gnt.
- Fairness bound: a requester held high is granted within sum over all other j of weff_j beats plus NUM-1 release cycles.

Decomposition:
- Package wrr_arb_pkg holds:
  - a state enum {IDLE, GRANT};
  - an onehot2idx function;
  - a weff helper (0 maps to 1).
- Sub-module: reuse the existing sp_arbiter (LSB_HIGH=1), two instances.
  - One instance picks over the masked requests.
  - One instance picks over the unmasked requests.
  - The top level holds the FSM, ptr, cnt and output registers.
- Target implementation size: about 150-250 lines total.

Test Plan:
1. NUM=4, WW=4. Hold rst=1 for 3 cycles with req=4'b1111 -> gnt=0 and gnt_vld=0 throughout; gnt=0001 in the first cycle after rst drops.
2. All weights 1, req=1111 constant -> gnt sequence 0001,0010,0100,1000,0001, one cycle each, gnt_vld continuously 1, gnt_id 0,1,2,3,0.
3. Weights w0=3, w1=1, w2=2, w3=0, req=1111 -> gnt 0001 x3, 0010 x1, 0100 x2, 1000 x1, then repeat. w3=0 behaves as 1; no gaps.
4. Early release: w0=4, req=0101, req0 drops after 2 beats ->
   - gnt0 high for 3 cycles (2 beats plus 1 non-beat cycle);
   - then gnt=0100 for 4 beats while req2 is held;
   - then IDLE once req=0.
5. Sole requester: req=1000, w3=2, change w3 to 7 mid-burst -> gnt stays 1000 continuously. The first burst counts 2, the reload uses 7, and the change within the burst is ignored.
6. Reset mid-burst: w1=5, req=0010, assert rst at beat 3 for 1 cycle -> gnt=0 the cycle after. Regrant 0010 occurs one cycle after rst drops, with cnt restarting at a full 5-beat burst.
